adder_arbiter: RTL and testbench

- Time-shares one `adder` instance (add/subtract via `invert_i_2`) between NUM_REQ independent requesters.
- Each requester issues operand pairs over a valid/ready handshake.
- The block grants one requester at a time, round-robin, and drives the shared adder from registered operands.
- It captures the sum/difference and flags, then returns them on a single tagged response channel.
- It sits between ALU-level clients and the shared adder datapath.

---
 rtl/adder_arbiter_if.sv | 48 ++++
 rtl/adder_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Request, shared-adder and tagged-response signals of adder_arbiter.
// slave is the arbiter's view; master is the requester/adder/consumer side.
interface adder_arbiter_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_sub;

   logic [WIDTH-1:0]         add_i_1;
   logic [WIDTH-1:0]         add_i_2;
   logic                     add_invert_i_2;
   logic                     add_enable;
   logic [WIDTH-1:0]         add_o;
   logic                     add_overflow_flag;
   logic                     add_zero_flag;
   logic                     add_exception_flag;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   logic                     rsp_overflow;
   logic                     rsp_zero;
   logic                     rsp_exception;

   modport slave (
      input  req_valid, req_a, req_b, req_sub,
      output req_ready,
      output add_i_1, add_i_2, add_invert_i_2, add_enable,
      input  add_o, add_overflow_flag, add_zero_flag, add_exception_flag,
      output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_exception,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_a, req_b, req_sub,
      input  req_ready,
      input  add_i_1, add_i_2, add_invert_i_2, add_enable,
      output add_o, add_overflow_flag, add_zero_flag, add_exception_flag,
      input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_exception,
      output rsp_ready
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one external adder among NUM_REQ requesters.
// One operation in flight: IDLE grants, EXEC drives the adder, RESP holds the tagged result.
module adder_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic           clk,
   input  logic           rst,
   adder_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic [ID_W-1:0]  cur_id;
   logic [ID_W-1:0]  last_grant;
   logic             add_en;

   logic             rsp_valid;
   logic [ID_W-1:0]  rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;
   logic             rsp_zero;
   logic             rsp_exception;

   logic [ID_W-1:0]  winner;
   logic             found;
   logic             grant;
   int unsigned      cand;

   // Scan upward from last_grant+1 with wrap, so the last winner has lowest priority.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(last_grant) + i) % NUM_REQ;
         if (!found && 1'(bus.req_valid >> cand)) begin
            found  = 1'b1;
            winner = ID_W'(cand);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state; req_ready is only ever raised for the winner of an IDLE cycle.
   always_comb begin
      state_next    = state;
      grant         = 1'b0;
      bus.req_ready = '0;
      case (state)
         IDLE: begin
            if (found && !rst) begin
               grant         = 1'b1;
               bus.req_ready = NUM_REQ'(1) << winner;
               state_next    = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture at grant, result capture after the single EXEC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a          <= '0;
         op_b          <= '0;
         op_sub        <= 1'b0;
         cur_id        <= '0;
         last_grant    <= ID_W'(NUM_REQ - 1);
         add_en        <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_result    <= '0;
         rsp_overflow  <= 1'b0;
         rsp_zero      <= 1'b0;
         rsp_exception <= 1'b0;
      end else begin
         add_en <= grant;
         case (state)
            IDLE: begin
               if (grant) begin
                  op_a       <= WIDTH'(bus.req_a >> (32'(winner) * WIDTH));
                  op_b       <= WIDTH'(bus.req_b >> (32'(winner) * WIDTH));
                  op_sub     <= 1'(bus.req_sub >> winner);
                  cur_id     <= winner;
                  last_grant <= winner;
               end
            end
            EXEC: begin
               rsp_result    <= bus.add_o;
               rsp_overflow  <= bus.add_overflow_flag;
               rsp_zero      <= bus.add_zero_flag;
               rsp_exception <= bus.add_exception_flag;
               rsp_id        <= cur_id;
               rsp_valid     <= 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.add_i_1        = op_a;
   assign bus.add_i_2        = op_b;
   assign bus.add_invert_i_2 = op_sub;
   assign bus.add_enable     = add_en;

   assign bus.rsp_valid      = rsp_valid;
   assign bus.rsp_id         = rsp_id;
   assign bus.rsp_result     = rsp_result;
   assign bus.rsp_overflow   = rsp_overflow;
   assign bus.rsp_zero       = rsp_zero;
   assign bus.rsp_exception  = rsp_exception;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural adder, arbitration/response reference model,
// scoreboard monitor, directed scenarios followed by randomized traffic.
module tb_adder_arbiter;
   localparam int unsigned W  = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));
   localparam longint MAXU = (longint'(1) << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) bus();

   adder_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Shared adder: carry-chain form; outputs are scrambled whenever enable is low.
   logic [W-1:0] add_bb;
   logic [W:0]   add_ext;
   logic         ovf_raw, zero_raw, exc_raw;
   assign add_bb   = bus.add_invert_i_2 ? ~bus.add_i_2 : bus.add_i_2;
   assign add_ext  = {1'b0, bus.add_i_1} + {1'b0, add_bb} + (W + 1)'(bus.add_invert_i_2);
   assign ovf_raw  = (bus.add_i_1[W-1] == add_bb[W-1]) && (add_ext[W-1] != bus.add_i_1[W-1]);
   assign zero_raw = (add_ext[W-1:0] == '0);
   assign exc_raw  = add_ext[W] ^ bus.add_invert_i_2;
   assign bus.add_o              = bus.add_enable ? add_ext[W-1:0] : ~add_ext[W-1:0];
   assign bus.add_overflow_flag  = bus.add_enable ? ovf_raw  : ~ovf_raw;
   assign bus.add_zero_flag      = bus.add_enable ? zero_raw : ~zero_raw;
   assign bus.add_exception_flag = bus.add_enable ? exc_raw  : ~exc_raw;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [W-1:0]  res;
      logic          ovf;
      logic          zero;
      logic          exc;
   } exp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb[$];
   int          grant_log[$];
   longint      grant_cyc[$];
   logic [N-1:0] granted = '0;
   longint      cyc = 0;
   bit          busy = 0;
   int          age = 0;
   int          mlast = N - 1;

   task automatic check(string name, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result: signed/unsigned wide arithmetic, then wrap to W bits.
   function automatic exp_t ref_op(int id, logic [W-1:0] a, logic [W-1:0] b, logic sub);
      exp_t   r;
      longint sa, sbv, sr, ua, ub;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'(a);
      ub  = longint'(b);
      sr  = sub ? sa - sbv : sa + sbv;
      r.id   = IW'(id);
      r.res  = W'(sub ? ua - ub : ua + ub);
      r.ovf  = (sr > MAXS) || (sr < MINS);
      r.zero = (r.res == '0);
      r.exc  = sub ? (ua < ub) : ((ua + ub) > MAXU);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Reference arbiter + scoreboard monitor, sampled at the falling edge.
   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      int           win;
      int           k;
      if (rst) begin
         sb.delete();
         busy    = 0;
         age     = 0;
         mlast   = N - 1;
         granted = '0;
         check("rst_req_ready", longint'(bus.req_ready), 0);
         check("rst_rsp_valid", longint'(bus.rsp_valid), 0);
         check("rst_add_enable", longint'(bus.add_enable), 0);
      end else begin
         exp_ready = '0;
         win = -1;
         if (busy) age++;
         if (!busy) begin
            for (int i = 1; i <= N; i++) begin
               k = (mlast + i) % N;
               if (win < 0 && bus.req_valid[IW'(k)]) win = k;
            end
         end
         if (win >= 0) exp_ready[IW'(win)] = 1'b1;
         check("req_ready", longint'(bus.req_ready), longint'(exp_ready));
         check("add_enable", longint'(bus.add_enable), longint'(busy && age == 1));
         check("rsp_valid", longint'(bus.rsp_valid), longint'(busy && age >= 2));
         granted = bus.req_ready;
         for (int j = 0; j < N; j++) begin
            if (bus.req_ready[IW'(j)]) begin
               grant_log.push_back(j);
               grant_cyc.push_back(cyc);
            end
         end
         if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               check("rsp_id", longint'(bus.rsp_id), longint'(sb[0].id));
               check("rsp_result", longint'(bus.rsp_result), longint'(sb[0].res));
               check("rsp_overflow", longint'(bus.rsp_overflow), longint'(sb[0].ovf));
               check("rsp_zero", longint'(bus.rsp_zero), longint'(sb[0].zero));
               check("rsp_exception", longint'(bus.rsp_exception), longint'(sb[0].exc));
               if (bus.rsp_ready) void'(sb.pop_front());
            end
         end
         if (busy && age >= 2 && bus.rsp_ready) busy = 0;
         if (win >= 0) begin
            sb.push_back(ref_op(win, W'(bus.req_a >> (win * W)), W'(bus.req_b >> (win * W)),
                                bus.req_sub[IW'(win)]));
            busy  = 1;
            age   = 0;
            mlast = win;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(int k, logic [W-1:0] a, logic [W-1:0] b, logic s);
      bus.req_a[k*W +: W]    = a;
      bus.req_b[k*W +: W]    = b;
      bus.req_sub[IW'(k)]    = s;
      bus.req_valid[IW'(k)]  = 1'b1;
   endtask

   task automatic drop(int k);
      bus.req_valid[IW'(k)] = 1'b0;
   endtask

   task automatic wait_grant(int k);
      int n = 0;
      tick();
      while (!granted[IW'(k)] && n < 50) begin
         tick();
         n++;
      end
      if (!granted[IW'(k)]) check("grant_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!bus.rsp_valid) check("rsp_timeout", 0, 1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 3))
         0:       return W'($urandom);
         1:       return 32'h7FFF_FFFF - W'($urandom_range(0, 1));
         2:       return W'($urandom_range(0, 15));
         default: return 32'h8000_0000 + W'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic raise_rand(int k);
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = rand_val();
      b = ($urandom_range(0, 3) == 0) ? a : rand_val();
      raise(k, a, b, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      int lat;
      int n;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_sub   = '0;
      bus.rsp_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (3) tick();
      check("reset_rsp_result", longint'(bus.rsp_result), 0);
      check("reset_rsp_id", longint'(bus.rsp_id), 0);
      check("reset_add_i_1", longint'(bus.add_i_1), 0);
      rst = 1'b0;

      // Single subtract from requester 0
      raise(0, 15, 39, 1'b1);
      wait_grant(0);
      drop(0);
      wait_rsp(lat);
      check("single_latency", lat, 1);
      check("single_result", longint'(bus.rsp_result), longint'(32'hFFFF_FFE8));
      check("single_id", longint'(bus.rsp_id), 0);
      check("single_zero", longint'(bus.rsp_zero), 0);
      tick();

      // Backpressure on requester 2 with requester 0 waiting
      bus.rsp_ready = 1'b0;
      raise(2, 272, 203, 1'b1);
      wait_grant(2);
      drop(2);
      raise(0, 5, 6, 1'b0);
      wait_rsp(lat);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", longint'(bus.rsp_valid), 1);
         check("bp_result", longint'(bus.rsp_result), 69);
         check("bp_no_ready", longint'(bus.req_ready), 0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      wait_grant(0);
      drop(0);
      wait_rsp(lat);
      tick();

      // Signed overflow on requester 1
      raise(1, 32'h7FFF_FFFF, 1, 1'b0);
      wait_grant(1);
      drop(1);
      wait_rsp(lat);
      check("ovf_result", longint'(bus.rsp_result), longint'(32'h8000_0000));
      check("ovf_flag", longint'(bus.rsp_overflow), 1);
      check("ovf_id", longint'(bus.rsp_id), 1);
      tick();

      // Zero result on requester 3
      raise(3, 210, 210, 1'b1);
      wait_grant(3);
      drop(3);
      wait_rsp(lat);
      check("zero_result", longint'(bus.rsp_result), 0);
      check("zero_flag", longint'(bus.rsp_zero), 1);
      check("zero_id", longint'(bus.rsp_id), 3);
      tick();

      // Reset while requester 2's op is executing
      raise(2, 100, 7, 1'b0);
      wait_grant(2);
      drop(2);
      rst = 1'b1;
      #1;
      check("midrst_add_enable", longint'(bus.add_enable), 0);
      check("midrst_rsp_valid", longint'(bus.rsp_valid), 0);
      check("midrst_req_ready", longint'(bus.req_ready), 0);
      check("midrst_rsp_result", longint'(bus.rsp_result), 0);
      tick();
      tick();
      rst = 1'b0;
      raise(1, 1, 2, 1'b0);
      raise(2, 3, 4, 1'b1);
      tick();
      check("midrst_first_grant", longint'(granted), 2);
      drop(1);
      wait_grant(2);
      drop(2);
      wait_rsp(lat);
      tick();

      // All requesters continuously valid from a fresh reset
      pulse_reset();
      grant_log.delete();
      grant_cyc.delete();
      for (int k = 0; k < N; k++) raise_rand(k);
      n = 0;
      while (grant_log.size() < 5 && n < 60) begin
         tick();
         for (int k = 0; k < N; k++) if (granted[IW'(k)]) raise_rand(k);
         n++;
      end
      bus.req_valid = '0;
      check("rr_grants_seen", longint'(grant_log.size() >= 5), 1);
      if (grant_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) check("rr_order", grant_log[i], exp_order[i]);
         for (int i = 1; i < 5; i++) check("rr_interval", grant_cyc[i] - grant_cyc[i-1], 3);
      end
      repeat (4) tick();

      // Randomized traffic with withdrawals and backpressure
      repeat (1500) begin
         tick();
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++) begin
            if (granted[IW'(k)]) begin
               if ($urandom_range(0, 1) == 1) raise_rand(k);
               else drop(k);
            end else if (bus.req_valid[IW'(k)]) begin
               if ($urandom_range(0, 19) == 0) drop(k);
            end else if ($urandom_range(0, 2) == 0) begin
               raise_rand(k);
            end
         end
      end

      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (10) tick();
      check("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
